// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for Nb = 4, 6 or 8 columns.
// The byte permutation sits in front of stage 1; later stages only carry registered data.
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [0:32*NB-1]   s_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_inv,
    output logic [TAG_W-1:0]   out_tag,
    output logic [0:32*NB-1]   shifted_state,
    output logic [2:0]         level
);

    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1..4");
    end

    function automatic int row_shift(input int r);
        if (NB == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    logic [0:W-1] fwd;
    logic [0:W-1] inv;
    logic [0:W-1] perm;

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SF = (c + row_shift(r)) % NB;
            localparam int SI = (c + NB - row_shift(r)) % NB;
            assign fwd[8*(4*c+r) +: 8] = s_state[8*(4*SF+r) +: 8];
            assign inv[8*(4*c+r) +: 8] = s_state[8*(4*SI+r) +: 8];
        end
    end

    assign perm = in_inv ? inv : fwd;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] md;
    logic [STAGES-1:0] ld;
    logic [0:W-1]      st [STAGES];
    logic [TAG_W-1:0]  tg [STAGES];

    // A stage can load if it or any stage after it has room, or the tail drains.
    for (genvar g = 0; g < STAGES; g++) begin : g_ld
        assign ld[g] = out_ready | ~(&vld[STAGES-1:g]);
    end

    logic in_fire;
    logic out_fire;

    assign in_ready  = reset & ld[0];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_valid     = vld[STAGES-1];
    assign out_inv       = md[STAGES-1];
    assign out_tag       = tg[STAGES-1];
    assign shifted_state = st[STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= '0;
            md  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st[i] <= '0;
                tg[i] <= '0;
            end
        end else begin
            if (ld[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    st[0] <= perm;
                    md[0] <= in_inv;
                    tg[0] <= in_tag;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (ld[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        st[i] <= st[i-1];
                        md[i] <= md[i-1];
                        tg[i] <= tg[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            level <= '0;
        end else if (in_fire && !out_fire) begin
            level <= level + 3'd1;
        end else if (out_fire && !in_fire) begin
            level <= level - 3'd1;
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: four instances cover NB=4/8 and STAGES=1/2/3.
module tb_shift_rows_pipe;

    localparam logic [127:0] P = 128'h216242c6db17a2abe6388d1dfa3c6260;
    localparam logic [127:0] I = 128'h213c8dabdb62621de6174260fa38a2c6;
    localparam logic [127:0] F = 128'h21178d60db3862c6e63c42abfa62a21d;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // A: NB=4, STAGES=1
    logic a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_inv;
    logic [3:0] a_in_tag, a_out_tag;
    logic [0:127] a_s_state, a_shifted_state;
    logic [2:0] a_level;

    shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
        .in_tag(a_in_tag), .s_state(a_s_state),
        .out_valid(a_out_valid), .out_ready(1'b1), .out_inv(a_out_inv),
        .out_tag(a_out_tag), .shifted_state(a_shifted_state), .level(a_level)
    );

    // B: NB=8, STAGES=1
    logic b_in_valid, b_in_ready, b_out_valid, b_out_inv;
    logic [3:0] b_out_tag;
    logic [0:255] b_s_state, b_shifted_state;
    logic [2:0] b_level;

    shift_rows_pipe #(.NB(8), .STAGES(1), .TAG_W(4)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(1'b1),
        .in_tag(4'd7), .s_state(b_s_state),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_inv(b_out_inv),
        .out_tag(b_out_tag), .shifted_state(b_shifted_state), .level(b_level)
    );

    // C: NB=4, STAGES=3
    logic c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_out_inv;
    logic [3:0] c_in_tag, c_out_tag;
    logic [0:127] c_s_state, c_shifted_state;
    logic [2:0] c_level;

    shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) u_c (
        .clk(clk), .reset(reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv),
        .in_tag(c_in_tag), .s_state(c_s_state),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_inv(c_out_inv),
        .out_tag(c_out_tag), .shifted_state(c_shifted_state), .level(c_level)
    );

    // D: NB=4, STAGES=2
    logic d_in_valid, d_in_ready, d_in_inv, d_out_valid, d_out_ready, d_out_inv;
    logic [3:0] d_in_tag, d_out_tag;
    logic [0:127] d_s_state, d_shifted_state;
    logic [2:0] d_level;

    shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) u_d (
        .clk(clk), .reset(reset),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_inv(d_in_inv),
        .in_tag(d_in_tag), .s_state(d_s_state),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_inv(d_out_inv),
        .out_tag(d_out_tag), .shifted_state(d_shifted_state), .level(d_level)
    );

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nx;
        int rx;
        reset = 1'b0;
        a_in_valid = 0; a_in_inv = 0; a_in_tag = 0; a_s_state = '0;
        b_in_valid = 0; b_s_state = '0;
        c_in_valid = 0; c_in_inv = 0; c_in_tag = 0; c_s_state = '0;
        c_out_ready = 0;
        d_in_valid = 0; d_in_inv = 0; d_in_tag = 0; d_s_state = '0;
        d_out_ready = 1;

        repeat (2) @(negedge clk);
        chk("rst_ready", 256'(a_in_ready), 256'(0));
        chk("rst_valid", 256'(a_out_valid), 256'(0));
        chk("rst_level", 256'(a_level), 256'(0));
        chk("rst_state", 256'(a_shifted_state), 256'(0));
        chk("rst_tag", 256'(a_out_tag), 256'(0));
        chk("rst_mode", 256'(a_out_inv), 256'(0));
        reset = 1'b1;
        #1;
        chk("ready_after_rst", 256'(a_in_ready), 256'(1));

        // single-stage inverse, forward and round trip
        a_in_valid = 1; a_in_inv = 1; a_in_tag = 3; a_s_state = P;
        @(negedge clk);
        a_in_valid = 0;
        chk("inv_valid", 256'(a_out_valid), 256'(1));
        chk("inv_state", 256'(a_shifted_state), 256'(I));
        chk("inv_tag", 256'(a_out_tag), 256'(3));
        chk("inv_mode", 256'(a_out_inv), 256'(1));
        a_in_valid = 1; a_in_inv = 0; a_in_tag = 5; a_s_state = P;
        @(negedge clk);
        a_in_valid = 0;
        chk("fwd_state", 256'(a_shifted_state), 256'(F));
        chk("fwd_mode", 256'(a_out_inv), 256'(0));
        chk("fwd_tag", 256'(a_out_tag), 256'(5));
        a_in_valid = 1; a_in_inv = 1; a_in_tag = 6; a_s_state = F;
        @(negedge clk);
        a_in_valid = 0;
        chk("round_trip", 256'(a_shifted_state), 256'(P));
        @(negedge clk);
        chk("a_drained", 256'(a_out_valid), 256'(0));

        // NB=8 inverse on a byte ramp
        for (int k = 0; k < 32; k++) b_s_state[8*k +: 8] = 8'(k);
        b_in_valid = 1;
        @(negedge clk);
        b_in_valid = 0;
        chk("nb8_valid", 256'(b_out_valid), 256'(1));
        chk("nb8_col0", 256'(b_shifted_state[0 +: 32]), 256'(32'h001d1613));
        for (int k = 0; k < 8; k++)
            chk($sformatf("nb8_row0_%0d", k),
                256'(b_shifted_state[32*k +: 8]), 256'(4*k));

        // backpressure on the 3-stage instance
        nx = 0; rx = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            c_out_ready = (cyc >= 6);
            if (nx < 5) begin
                c_in_valid = 1;
                c_in_inv = (nx % 2 == 0);
                c_in_tag = 4'(nx);
                c_s_state = (nx % 2 == 0) ? P : I;
            end else begin
                c_in_valid = 0;
            end
            if (cyc >= 3 && cyc < 6) c_s_state = ~P;
            #1;
            if (cyc < 3) chk("bp_fill_level", 256'(c_level), 256'(cyc));
            if (cyc >= 3 && cyc < 6) begin
                chk("bp_stall_ready", 256'(c_in_ready), 256'(0));
                chk("bp_stall_level", 256'(c_level), 256'(3));
                chk("bp_stall_valid", 256'(c_out_valid), 256'(1));
                chk("bp_stall_state", 256'(c_shifted_state), 256'(I));
                chk("bp_stall_tag", 256'(c_out_tag), 256'(0));
            end
            if (c_out_valid && c_out_ready) begin
                if (rx < 5) begin
                    chk("bp_state", 256'(c_shifted_state),
                        256'((rx % 2 == 0) ? I : P));
                    chk("bp_tag", 256'(c_out_tag), 256'(rx));
                    chk("bp_mode", 256'(c_out_inv), 256'(rx % 2 == 0));
                end else begin
                    chk("bp_extra", 256'(1), 256'(0));
                end
                rx++;
            end
            if (c_in_valid && c_in_ready) nx++;
            @(negedge clk);
        end
        c_in_valid = 0;
        chk("bp_count", 256'(rx), 256'(5));
        chk("bp_sent", 256'(nx), 256'(5));

        // full-rate streaming on the 2-stage instance
        for (int cyc = 0; cyc < 13; cyc++) begin
            if (cyc < 10) begin
                d_in_valid = 1;
                d_in_inv = (cyc % 2 == 0);
                d_in_tag = 4'(cyc);
                d_s_state = (cyc % 2 == 0) ? P : I;
            end else begin
                d_in_valid = 0;
            end
            #1;
            if (cyc < 10) chk("fr_ready", 256'(d_in_ready), 256'(1));
            if (cyc < 2) chk("fr_lead", 256'(d_out_valid), 256'(0));
            if (cyc >= 2 && cyc < 12) begin
                chk("fr_valid", 256'(d_out_valid), 256'(1));
                chk("fr_tag", 256'(d_out_tag), 256'(cyc - 2));
                chk("fr_state", 256'(d_shifted_state),
                    256'((cyc % 2 == 0) ? I : P));
            end
            if (cyc >= 2 && cyc < 10) chk("fr_level", 256'(d_level), 256'(2));
            if (cyc == 12) chk("fr_drained", 256'(d_out_valid), 256'(0));
            @(negedge clk);
        end

        // reset while two transactions are in flight
        d_out_ready = 0;
        d_in_valid = 1; d_in_inv = 1; d_in_tag = 9; d_s_state = P;
        @(negedge clk);
        d_in_tag = 10;
        @(negedge clk);
        d_in_valid = 0;
        chk("mid_level", 256'(d_level), 256'(2));
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 256'(d_out_valid), 256'(0));
        chk("mrst_level", 256'(d_level), 256'(0));
        chk("mrst_state", 256'(d_shifted_state), 256'(0));
        chk("mrst_ready", 256'(d_in_ready), 256'(0));
        reset = 1'b1;
        d_out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("no_stale", 256'(d_out_valid), 256'(0));
            @(negedge clk);
        end
        d_in_valid = 1; d_in_inv = 0; d_in_tag = 11; d_s_state = I;
        @(negedge clk);
        d_in_valid = 0;
        chk("post_lat1", 256'(d_out_valid), 256'(0));
        @(negedge clk);
        chk("post_valid", 256'(d_out_valid), 256'(1));
        chk("post_state", 256'(d_shifted_state), 256'(P));
        chk("post_tag", 256'(d_out_tag), 256'(11));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, pipelined Rijndael ShiftRows / InvShiftRows unit for the decryptor datapath.
- Supports block widths Nb = 4, 6 or 8 columns and selects forward or inverse per transaction.
- Uses a valid/ready elastic pipeline and carries a sideband tag per transaction.
- Sits between the round-key-add stage and the (inv) S-box stage, and replaces the fixed combinational 128-bit inverse shifter.

Parameters:
NB, 4, state columns; legal values are 4, 6, 8; any other value is an elaboration error.
STAGES, 1, number of register stages (1..4); STAGES is also the latency.
TAG_W, 4, width of the sideband tag carried with each state.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  unit can accept an input this cycle
in_inv  input  1  mode select: 1 = InvShiftRows, 0 = ShiftRows
in_tag  input  TAG_W  sideband tag, passed through unchanged
s_state  input  [0:32*NB-1]  input state
out_valid  output  1  output transaction valid
out_ready  input  1  downstream accepts the output
out_inv  output  1  mode of the output transaction
out_tag  output  TAG_W  tag of the output transaction
shifted_state  output  [0:32*NB-1]  shifted state
level  output  3  number of occupied stages (0..STAGES)

Behaviour:
- Byte layout:
  - Byte k occupies bits [8k:8k+7], column-major: k = 4c + r, with r in 0..3 and c in 0..NB-1.
  - Bit 0 is the MSB of byte 0.
- Row offsets s_r:
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Mapping:
  - Inverse: out[r][c] = in[r][(c - s_r) mod NB].
  - Forward: out[r][c] = in[r][(c + s_r) mod NB].
  - Row 0 is never moved.
- Permutation placement: the byte permutation is applied combinationally in front of stage 1. Stages 2..STAGES only move registered data.
- Each stage holds: valid bit, state, inv, tag.
- Stage i loads when the stage is empty, or when its contents move forward in the same cycle.
  - The last stage moves when out_ready = 1.
  - Stage i moves when stage i+1 loads.
- in_ready = stage 1 can load. It is combinational from out_ready through the stage-full chain, with no registered bubble.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - out_valid = valid bit of the last stage.
  - out_* are driven directly from the last-stage registers.
- Throughput and latency:
  - Throughput is 1 transaction per cycle while out_ready = 1.
  - Latency is STAGES cycles from input transfer to out_valid.
- Stall rules:
  - While out_valid = 1 and out_ready = 0, the out_* values hold stable.
  - Stages fill back-to-front until in_ready = 0 at level = STAGES.
- Input changes while in_valid = 1 and in_ready = 0 are ignored; nothing is captured.
- level:
  - +1 on an input transfer without an output transfer.
  - -1 on an output transfer without an input transfer.
  - Unchanged when both or neither occur.
  - Simultaneous input and output transfers at full occupancy are legal and keep level = STAGES.
- Mode and tag are per transaction; back-to-back transactions may alternate in_inv with no penalty.
- Reset (reset = 0 sampled on a clk edge):
  - All stage valid bits clear, level = 0, out_valid = 0.
  - shifted_state, out_tag and out_inv = 0.
  - in_ready = 0 during reset, and goes to 1 on the first cycle after reset is released.
  - Reset mid-stream discards all in-flight transactions; no partial output appears.
- Data registers are also cleared on reset, so that X never appears on outputs.

Test Plan:
- Inverse, NB=4, STAGES=1:
  - Stimulus: s_state = 216242c6db17a2abe6388d1dfa3c6260, in_inv = 1, tag = 3.
  - Required: one cycle later, out_valid = 1, shifted_state = 213c8dabdb62621de6174260fa38a2c6, out_tag = 3.
- Forward, same input:
  - Stimulus: in_inv = 0.
  - Required: shifted_state = 21178d60db3862c6e63c42abfa62a21d.
  - Feeding that result back with in_inv = 1 returns 216242c6db17a2abe6388d1dfa3c6260.
- NB=8 inverse:
  - Stimulus: byte ramp 00..1f.
  - Required: output bytes 0..3 = 00 1d 16 13; row 0 bytes (0, 4, ..., 28) unchanged.
- Backpressure, STAGES=3:
  - Stimulus: stream 5 transactions with alternating in_inv and tags 0..4; hold out_ready = 0 for 6 cycles, then release.
  - Required:
    - level rises to 3 and in_ready drops to 0.
    - Outputs hold stable during the stall.
    - After release, all 5 results exit in order with correct tags and modes: no loss, no duplication.
- Full-rate streaming:
  - Stimulus: STAGES=2, in_valid = out_ready = 1 for 10 cycles.
  - Required: 10 outputs on consecutive cycles starting at cycle 2; level stays at 2 while the stream is flowing.
- Reset mid-operation:
  - Stimulus: assert reset = 0 for 1 cycle with level = 2.
  - Required:
    - Next cycle: out_valid = 0, level = 0, shifted_state = 0.
    - No stale transaction is emitted afterwards.
    - A subsequent input appears after exactly STAGES cycles.
